// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encodings,
// master indices, bus widths and the request payload struct.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Master indices as stored in last_grant
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  // Request payload a master presents to the slave side
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we;
    logic              rd;
  } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Bus transaction watchdog: counts granted cycles without s_ready and
// flags a forced completion plus a sticky irq. Only built with BUS_TIMEOUT_EN.
`ifdef BUS_TIMEOUT_EN
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic s_ready,
  output logic timeout_c,
  output logic irq
);

  logic [CNT_W-1:0] count;

  // Wait counter: cleared outside a grant, so every grant starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (!s_ready) begin
      count <= count + CNT_W'(1);
    end
  end

  // A real s_ready in the expiry cycle takes priority over the timeout
  assign timeout_c = active && !s_ready && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else if (timeout_c) begin
      irq <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter (CPU / DMA) in front of the memory
// mapper. Grant is held until the slave completes; a DONE bubble separates
// owners. Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_a,
  input  logic [DATA_W-1:0] m0_d,
  input  logic              m0_we,
  input  logic              m0_rd,
  output logic [DATA_W-1:0] m0_spo,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_a,
  input  logic [DATA_W-1:0] m1_d,
  input  logic              m1_we,
  input  logic              m1_rd,
  output logic [DATA_W-1:0] m1_spo,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] s_a,
  output logic [DATA_W-1:0] s_d,
  output logic              s_we,
  output logic              s_rd,
  input  logic [DATA_W-1:0] s_spo,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic              irq
);

  logic [1:0]        state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic              owner;
  logic              done_c;
  logic              timeout_c;
  logic [DATA_W-1:0] rsp_spo;
  bus_req_t          m0_bus, m1_bus, sel;

  assign m0_bus = {m0_a, m0_d, m0_we, m0_rd};
  assign m1_bus = {m1_a, m1_d, m1_we, m1_rd};

`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active    ((state == ST_GNT0) || (state == ST_GNT1)),
    .s_ready   (s_ready),
    .timeout_c (timeout_c),
    .irq       (irq)
  );
`else
  logic [CNT_W+DATA_W-1:0] unused_cfg;
  assign unused_cfg = {CNT_W'(TIMEOUT_CYCLES), ERR_DATA};
  assign timeout_c  = 1'b0;
  assign irq        = 1'b0;
`endif

  // State and round-robin history; reset favours m0 on the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= M1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic and the combinational slave/master routing
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner          = M0;
    sel            = '0;
    done_c         = 1'b0;
    rsp_spo        = '0;
    grant          = 2'b00;
    s_a            = '0;
    s_d            = '0;
    s_we           = 1'b0;
    s_rd           = 1'b0;
    m0_spo         = '0;
    m0_ready       = 1'b0;
    m1_spo         = '0;
    m1_ready       = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((m0_rd | m0_we) && (m1_rd | m1_we)) begin
          state_nxt = (last_grant == M1) ? ST_GNT0 : ST_GNT1;
        end else if (m0_rd | m0_we) begin
          state_nxt = ST_GNT0;
        end else if (m1_rd | m1_we) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        owner   = (state == ST_GNT1) ? M1 : M0;
        sel     = (owner == M1) ? m1_bus : m0_bus;
        grant   = (owner == M1) ? 2'b10 : 2'b01;
        s_a     = sel.a;
        s_d     = sel.d;
        s_we    = sel.we && !timeout_c;
        s_rd    = sel.rd && !timeout_c;
        done_c  = s_ready || timeout_c;
        rsp_spo = timeout_c ? ERR_DATA : s_spo;
        if (owner == M1) begin
          m1_ready = done_c;
          m1_spo   = rsp_spo;
        end else begin
          m0_ready = done_c;
          m0_spo   = rsp_spo;
        end
        if (done_c) begin
          state_nxt      = ST_DONE;
          last_grant_nxt = owner;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
